// File: rtl/icache_pkg.sv
// Shared constants and FSM encoding for the direct-mapped instruction cache.
package icache_pkg;

    localparam int unsigned ICACHE_INDEX_W = 7;
    localparam int unsigned INST_ADDR_W    = 32;
    localparam int unsigned INST_W         = 32;
    localparam logic [INST_W-1:0] ZERO_WORD = '0;
    localparam logic RST_ENABLE = 1'b0;

    typedef enum logic {
        ICACHE_IDLE,
        ICACHE_FETCH
    } icache_state_e;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational read port, single write port, synchronous valid clear.
module icache_array
    import icache_pkg::*;
#(
    parameter int unsigned INDEX_W = ICACHE_INDEX_W,
    parameter int unsigned TAG_W   = INST_ADDR_W - ICACHE_INDEX_W - 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic [INDEX_W-1:0] rd_idx_i,
    output logic               rd_valid_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic [INST_W-1:0]  rd_data_o,
    input  logic               we_i,
    input  logic [INDEX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [INST_W-1:0]  wr_data_i
);

    localparam int unsigned NumLines = 2 ** INDEX_W;

    logic [NumLines-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q  [NumLines];
    logic [TAG_W-1:0]    tag_d  [NumLines];
    logic [INST_W-1:0]   data_q [NumLines];
    logic [INST_W-1:0]   data_d [NumLines];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (we_i) begin
            valid_d[wr_idx_i] = 1'b1;
            tag_d[wr_idx_i]   = wr_tag_i;
            data_d[wr_idx_i]  = wr_data_i;
        end
        // A clear in the same cycle as a write leaves the line invalid.
        if (clr_i) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data contents survive reset; only the valid bits are cleared.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped I-cache with one word per line, combinational hit and single-word miss refill.
module icache
    import icache_pkg::*;
#(
    parameter int unsigned INDEX_W = ICACHE_INDEX_W,
    parameter int unsigned ADDR_W  = INST_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    output logic              inst_enable_o,
    output logic [INST_W-1:0] inst_data_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ready_i,
    input  logic [INST_W-1:0] mem_data_i
);

    localparam int unsigned TAG_W = ADDR_W - INDEX_W - 2;
    localparam logic [ADDR_W-1:0] AlignMask = {{(ADDR_W-2){1'b1}}, 2'b00};

    icache_state_e     state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              drop_q, drop_d;

    logic [ADDR_W-1:0]  addr_aligned;
    logic [INDEX_W-1:0] addr_idx;
    logic [TAG_W-1:0]   addr_tag;
    logic               rd_valid;
    logic [TAG_W-1:0]   rd_tag;
    logic [INST_W-1:0]  rd_data;
    logic               in_reset;
    logic               hit;
    logic               fill_we;
    logic               fwd;

    assign addr_aligned = inst_addr_i & AlignMask;
    assign addr_idx     = inst_addr_i[INDEX_W+1:2];
    assign addr_tag     = inst_addr_i[ADDR_W-1:INDEX_W+2];
    assign in_reset     = (rst == RST_ENABLE);

    icache_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (flush_i),
        .rd_idx_i   (addr_idx),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .we_i       (fill_we),
        .wr_idx_i   (mem_addr_q[INDEX_W+1:2]),
        .wr_tag_i   (mem_addr_q[ADDR_W-1:INDEX_W+2]),
        .wr_data_i  (mem_data_i)
    );

    assign hit = !in_reset && rd_valid && (rd_tag == addr_tag) && !flush_i;

    // A dropped fill (flush seen during FETCH) is neither written nor forwarded.
    assign fill_we = (state_q == ICACHE_FETCH) && mem_ready_i && !drop_q && !flush_i;
    assign fwd     = !in_reset && fill_we && (mem_addr_q == addr_aligned);

    always_comb begin
        inst_enable_o = 1'b0;
        inst_data_o   = ZERO_WORD;
        if (hit) begin
            inst_enable_o = 1'b1;
            inst_data_o   = rd_data;
        end else if (fwd) begin
            inst_enable_o = 1'b1;
            inst_data_o   = mem_data_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        drop_d     = drop_q;
        unique case (state_q)
            ICACHE_IDLE: begin
                if (!hit && !flush_i) begin
                    state_d    = ICACHE_FETCH;
                    mem_req_d  = 1'b1;
                    mem_addr_d = addr_aligned;
                end
            end
            ICACHE_FETCH: begin
                if (flush_i) begin
                    drop_d = 1'b1;
                end
                if (mem_ready_i) begin
                    state_d   = ICACHE_IDLE;
                    mem_req_d = 1'b0;
                    drop_d    = 1'b0;
                end
            end
            default: state_d = ICACHE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q    <= ICACHE_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            drop_q     <= drop_d;
        end
    end

    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped instruction cache directly upstream of the IF stage.
- Serves the IF fetch address with a combinational hit, so IF stalls only on a miss.
- On a miss, fetches one 32-bit word from the memory controller through a req/ready handshake, fills the line and forwards the word.
- One instruction word per line. Invalidation via flush_i (fence.i).

Parameters:
INDEX_W, 7, index bits; the cache holds 2^INDEX_W lines
ADDR_W, 32, address width; tag = addr[ADDR_W-1:INDEX_W+2], index = addr[INDEX_W+1:2], addr[1:0] ignored

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  synchronous, active-low reset (rst==0 resets on the next rising clk edge)
flush_i  in  1  invalidate all lines (fence.i)
inst_addr_i  in  ADDR_W  fetch address from IF
inst_enable_o  out  1  inst_data_o valid for inst_addr_i this cycle; IF stall = !inst_enable_o
inst_data_o  out  32  instruction word; 0 when inst_enable_o=0
mem_req_o  out  1  fetch request to the memory controller
mem_addr_o  out  ADDR_W  word-aligned fetch address ({addr[31:2],2'b00})
mem_ready_i  in  1  one-cycle pulse: mem_data_i is valid for the outstanding request
mem_data_i  in  32  fetched word

Behaviour:
- Reset (rst==0 at a rising edge):
  - All valid bits cleared; state IDLE; drop flag cleared.
  - mem_req_o=0, mem_addr_o=0.
  - While rst==0, inst_enable_o=0 and inst_data_o=0 combinationally.
  - Tag and data arrays are not cleared.
- Hit, combinational: valid[idx] && tag[idx]==tag(inst_addr_i) && !flush_i gives inst_enable_o=1 and inst_data_o=data[idx] in the same cycle, in any state.
- States: IDLE, FETCH.
- IDLE:
  - A miss with !flush_i goes to FETCH at the next edge.
  - That edge registers mem_req_o=1 and mem_addr_o to the aligned inst_addr_i, and latches the fill address.
  - Miss latency: one cycle before the request, then memory latency.
- FETCH handshake:
  - mem_req_o and mem_addr_o are held stable until mem_ready_i=1 is sampled.
  - At that edge: mem_req_o=0 and the state returns to IDLE.
  - If the drop flag is clear, data and tag are written and valid[idx] is set.
- Forwarding: in the cycle mem_ready_i=1 with the drop flag clear and fill address == aligned inst_addr_i, inst_enable_o=1 and inst_data_o=mem_data_i.
- PC change mid-FETCH (branch): the outstanding fill still completes and is written but not forwarded. The new address is looked up in IDLE on the next cycle and may trigger a new miss.
- flush_i:
  - Clears all valid bits at the edge and forces inst_enable_o=0 in that cycle.
  - In FETCH, flush_i sets the drop flag, so the outstanding fill is neither written nor forwarded.
  - A flush and a fill in the same cycle resolve to flush winning: the line stays invalid.
  - The drop flag clears on return to IDLE.
- mem_ready_i is ignored in IDLE.
- Index aliasing: a fill overwrites the line; no replacement policy is needed.
- Only one request is outstanding at a time; no new request is issued in the same cycle as a fill. The earliest next request is asserted one edge after the return to IDLE.

Decomposition:
- The shared defines file holds `InstAddrBus, `InstBus, `ZeroWord, `ICacheIndexW and the state encodings ICACHE_IDLE and ICACHE_FETCH.
- Reset polarity is expressed by a define for the active-low level.
- Natural sub-module: icache_array.
  - Valid, tag and data storage.
  - Combinational read port.
  - Single write port.
  - Synchronous valid clear for reset and flush.
- The icache top keeps the FSM, hit compare, forwarding mux and memory handshake.

Test Plan:
1. Reset with rst=0 for 2 cycles, then inst_addr_i=0x0 -> cycle 0 after reset inst_enable_o=0; next cycle mem_req_o=1, mem_addr_o=0x0; mem_ready_i=1 with mem_data_i=0x00000013 -> inst_enable_o=1, inst_data_o=0x00000013 that cycle; next cycle hit with mem_req_o=0.
2. Warm line at 0x4 (0x00100093), then hold inst_addr_i=0x4 -> inst_enable_o=1 every cycle, mem_req_o never asserted.
3. Aliasing with INDEX_W=7: fill 0x0004 then 0x0204 (same index, different tag) -> 0x0204 misses; after its fill, 0x0004 misses again.
4. PC change during FETCH for 0x10, inst_addr_i moves to 0x20 before mem_ready_i -> no forwarding for 0x20; 0x10 becomes valid (later hit); next request mem_addr_o=0x20.
5. flush_i pulsed during FETCH for 0x30, fill arrives later -> line stays invalid; a later access to 0x30 re-requests; all previously valid lines miss after the flush.
6. mem_ready_i pulsed in IDLE, and a misaligned inst_addr_i=0x8+3 -> pulse ignored with no state change; 0x0B served by the 0x8 line with mem_addr_o=0x8.
